// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: memory-op encodings and FSM state type.
package mem_stage_pkg;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LW  = 4'd3;
  localparam logic [3:0] MEM_LBU = 4'd4;
  localparam logic [3:0] MEM_LHU = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load-value extension: picks byte/half/word from the assembled buffer and
// sign- or zero-extends it according to the load op.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] byte_buf,
  input  logic [3:0]  op,
  output logic [31:0] ext_data
);

  always_comb begin
    ext_data = byte_buf;
    case (op)
      MEM_LB:  ext_data = {{24{byte_buf[7]}}, byte_buf[7:0]};
      MEM_LBU: ext_data = {24'd0, byte_buf[7:0]};
      MEM_LH:  ext_data = {{16{byte_buf[15]}}, byte_buf[15:0]};
      MEM_LHU: ext_data = {16'd0, byte_buf[15:0]};
      default: ext_data = byte_buf;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-serial loads/stores over an 8-bit RAM port.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_sdata_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i,
  output logic              misalign_o
);

  mem_state_e        state;
  logic [2:0]        cnt;
  logic [31:0]       byte_buf;

  logic [2:0]        n_bytes;
  logic              is_load;
  logic              is_store;
  logic              is_mem;
  logic              misalign;
  logic              start;
  logic              access;
  logic [ADDR_W-1:0] addr_k;
  logic [7:0]        store_byte;
  logic [31:0]       ext_data;

  always_comb begin
    n_bytes  = 3'd0;
    is_load  = 1'b0;
    is_store = 1'b0;
    case (mem_op_i)
      MEM_LB, MEM_LBU: begin n_bytes = 3'd1; is_load  = 1'b1; end
      MEM_LH, MEM_LHU: begin n_bytes = 3'd2; is_load  = 1'b1; end
      MEM_LW:          begin n_bytes = 3'd4; is_load  = 1'b1; end
      MEM_SB:          begin n_bytes = 3'd1; is_store = 1'b1; end
      MEM_SH:          begin n_bytes = 3'd2; is_store = 1'b1; end
      MEM_SW:          begin n_bytes = 3'd4; is_store = 1'b1; end
      default: ;
    endcase
  end

  assign is_mem = is_load | is_store;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (state == ST_IDLE) &&
                    ((n_bytes == 3'd2 && mem_addr_i[0]) ||
                     (n_bytes == 3'd4 && mem_addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // cnt is 0 in IDLE, so addr_k doubles as the first-byte address.
  assign start      = (state == ST_IDLE) && is_mem && !misalign;
  assign access     = start || ((state == ST_BUSY) && (cnt < n_bytes));
  assign addr_k     = mem_addr_i + ADDR_W'(cnt);
  assign store_byte = mem_sdata_i[{cnt[1:0], 3'b000} +: 8];

  mem_load_ext u_load_ext (
    .byte_buf (byte_buf),
    .op       (mem_op_i),
    .ext_data (ext_data)
  );

  // Outputs are forced low while reset is held so no RAM write can escape.
  assign wd_o       = rst ? 5'd0 : wd_i;
  assign wreg_o     = rst ? 1'b0 : (wreg_i && !misalign);
  assign wdata_o    = rst ? 32'd0 :
                      ((state == ST_DONE && is_load) ? ext_data : wdata_i);
  assign stallreq_o = !rst && (start || state == ST_BUSY);
  assign ram_a_o    = (!rst && access) ? addr_k : '0;
  assign ram_wr_o   = !rst && access && is_store;
  assign ram_dout_o = (!rst && access && is_store) ? store_byte : 8'd0;
  assign misalign_o = !rst && misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= 3'd0;
      byte_buf <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt <= 3'd1;
            // A single-byte store is finished by its IDLE write.
            if (is_store && n_bytes == 3'd1) state <= ST_DONE;
            else                             state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (is_load) begin
            for (int k = 0; k < 4; k++) begin
              if (cnt == 3'(k + 1)) byte_buf[8*k +: 8] <= ram_din_i;
            end
            if (cnt < n_bytes) cnt   <= cnt + 3'd1;
            else               state <= ST_DONE;
          end else if (cnt < n_bytes) begin
            cnt <= cnt + 3'd1;
            if (cnt + 3'd1 == n_bytes) state <= ST_DONE;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          cnt   <= 3'd0;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table of loads/stores/NOPs with a
// scoreboard of expected write-back data, plus reset and address-sequence cases.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_sdata_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;
  logic [31:0] ram_a_o;
  logic [7:0]  ram_dout_o;
  logic        ram_wr_o;
  logic [7:0]  ram_din_i;
  logic        misalign_o;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
    .ram_a_o(ram_a_o), .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o),
    .ram_din_i(ram_din_i), .misalign_o(misalign_o)
  );

  // RAM model: registered read, write on strobe, bench pokes via a side port.
  logic [7:0]  mem [0:4095];
  logic        poke_en = 1'b0;
  logic [11:0] poke_addr = 12'd0;
  logic [7:0]  poke_data = 8'd0;
  int          wr_total = 0;

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (ram_wr_o) begin
      mem[ram_a_o[11:0]] <= ram_dout_o;
      wr_total <= wr_total + 1;
    end
    ram_din_i <= mem[ram_a_o[11:0]];
  end

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] addr_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    poke_addr = a; poke_data = d; poke_en = 1'b1;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic go_nop();
    @(posedge clk); #1;
    mem_op_i = MEM_NOP; wreg_i = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] wdata;
    logic        wreg;
    logic [31:0] exp_wdata;
    int          exp_stall;
    int          exp_wr;
    logic        exp_wreg;
    logic        exp_mis;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [31:0] wdata,
                              input logic wreg, input logic [31:0] exp_wdata,
                              input int exp_stall, input int exp_wr,
                              input logic exp_wreg, input logic exp_mis);
    vec_t v;
    v.op = op; v.addr = addr; v.sdata = sdata; v.wdata = wdata; v.wreg = wreg;
    v.exp_wdata = exp_wdata; v.exp_stall = exp_stall; v.exp_wr = exp_wr;
    v.exp_wreg = exp_wreg; v.exp_mis = exp_mis;
    return v;
  endfunction

  // Drives one op the cycle after the previous one completes, counts stall
  // cycles and checks the write-back cycle against the scoreboard.
  task automatic run_op(input vec_t v, input logic [4:0] wd, input string tag);
    int stall;
    int wr_start;
    logic [31:0] exp;
    @(posedge clk); #1;
    mem_op_i = v.op; mem_addr_i = v.addr; mem_sdata_i = v.sdata;
    wdata_i = v.wdata; wreg_i = v.wreg; wd_i = wd;
    wr_start = wr_total;
    exp_q.push_back(v.exp_wdata);
    addr_log.delete();
    stall = 0;
    forever begin
      @(negedge clk);
      if (!stallreq_o) break;
      addr_log.push_back(ram_a_o);
      stall++;
      if (stall > 20) begin
        tests++; fails++;
        $display("FAIL %s_timeout: stall still high after %0d cycles, expected release", tag, stall);
        break;
      end
    end
    exp = exp_q.pop_front();
    check({tag, "_wdata"}, wdata_o, exp);
    check({tag, "_stall"}, 32'(stall), 32'(v.exp_stall));
    check({tag, "_wr_count"}, 32'(wr_total - wr_start), 32'(v.exp_wr));
    check({tag, "_wd"}, {27'd0, wd_o}, {27'd0, wd});
    check({tag, "_wreg"}, {31'd0, wreg_o}, {31'd0, v.exp_wreg});
    check({tag, "_misalign"}, {31'd0, misalign_o}, {31'd0, v.exp_mis});
    check({tag, "_wr_at_done"}, {31'd0, ram_wr_o}, 32'd0);
    $display("[TB] %s op=%0d addr=0x%08h wdata_o=0x%08h stall=%0d", tag, v.op, v.addr, wdata_o, stall);
  endtask

  vec_t vecs[13];

  initial begin
    rst = 1'b1;
    wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h55;
    mem_op_i = MEM_LW; mem_addr_i = 32'h100; mem_sdata_i = 32'hFFFF_FFFF;
    #12;
    check("rst_wd", {27'd0, wd_o}, 32'd0);
    check("rst_wreg", {31'd0, wreg_o}, 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_stall", {31'd0, stallreq_o}, 32'd0);
    check("rst_ram_a", ram_a_o, 32'd0);
    check("rst_ram_wr", {31'd0, ram_wr_o}, 32'd0);
    mem_op_i = MEM_NOP; wreg_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    poke(12'h100, 8'h78); poke(12'h101, 8'h56); poke(12'h102, 8'h34); poke(12'h103, 8'h12);
    poke(12'h104, 8'h9A); poke(12'h105, 8'hBC); poke(12'h106, 8'hDE); poke(12'h107, 8'hF0);
    poke(12'h007, 8'h80); poke(12'h010, 8'hFF); poke(12'h011, 8'h80);
    for (int i = 0; i < 4; i++) poke(12'h400 + 12'(i), 8'h00);

    vecs[0]  = mk(MEM_LW,  32'h100, 32'h0, 32'h0, 1'b1, 32'h1234_5678, 5, 0, 1'b1, 1'b0);
    vecs[1]  = mk(MEM_LB,  32'h007, 32'h0, 32'h0, 1'b1, 32'hFFFF_FF80, 2, 0, 1'b1, 1'b0);
    vecs[2]  = mk(MEM_LBU, 32'h007, 32'h0, 32'h0, 1'b1, 32'h0000_0080, 2, 0, 1'b1, 1'b0);
    vecs[3]  = mk(MEM_LHU, 32'h010, 32'h0, 32'h0, 1'b1, 32'h0000_80FF, 3, 0, 1'b1, 1'b0);
    vecs[4]  = mk(MEM_LH,  32'h010, 32'h0, 32'h0, 1'b1, 32'hFFFF_80FF, 3, 0, 1'b1, 1'b0);
    vecs[5]  = mk(MEM_SW,  32'h200, 32'hDEAD_BEEF, 32'h204, 1'b0, 32'h204, 4, 4, 1'b0, 1'b0);
    vecs[6]  = mk(MEM_SH,  32'h300, 32'h1234_CAFE, 32'h300, 1'b0, 32'h300, 2, 2, 1'b0, 1'b0);
    vecs[7]  = mk(MEM_SB,  32'h310, 32'h0000_00A5, 32'h310, 1'b0, 32'h310, 1, 1, 1'b0, 1'b0);
    vecs[8]  = mk(MEM_NOP, 32'h0,   32'h0, 32'h55, 1'b1, 32'h55, 0, 0, 1'b1, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    vecs[9]  = mk(MEM_LW,  32'h102, 32'h0, 32'h77, 1'b1, 32'h77, 0, 0, 1'b0, 1'b1);
`else
    vecs[9]  = mk(MEM_LW,  32'h102, 32'h0, 32'h77, 1'b1, 32'hBC9A_1234, 5, 0, 1'b1, 1'b0);
`endif
    vecs[10] = mk(MEM_LW,  32'h200, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 5, 0, 1'b1, 1'b0);
    vecs[11] = mk(MEM_LH,  32'h300, 32'h0, 32'h0, 1'b1, 32'hFFFF_CAFE, 3, 0, 1'b1, 1'b0);
    vecs[12] = mk(MEM_LBU, 32'h310, 32'h0, 32'h0, 1'b1, 32'h0000_00A5, 2, 0, 1'b1, 1'b0);

    // Consecutive entries run back-to-back, including LW->SB style handoffs.
    for (int i = 0; i < 13; i++) run_op(vecs[i], 5'(i + 1), $sformatf("vec%0d", i));

    // Word load address sequence.
    run_op(vecs[0], 5'd20, "lw_seq");
    for (int k = 0; k < 4; k++)
      check($sformatf("lw_addr%0d", k), (k < addr_log.size()) ? addr_log[k] : 32'hFFFF_FFFF, 32'h100 + 32'(k));

    // LW immediately followed by SB: SB's write must land after the load completes.
    run_op(vecs[0], 5'd21, "b2b_lw");
    run_op(mk(MEM_SB, 32'h101, 32'h0000_0042, 32'h0, 1'b0, 32'h0, 1, 1, 1'b0, 1'b0), 5'd22, "b2b_sb");
    go_nop();
    check("b2b_mem101", {24'd0, mem[12'h101]}, 32'h42);
    check("b2b_mem100", {24'd0, mem[12'h100]}, 32'h78);

    // Reset in the middle of a word store.
    @(posedge clk); #1;
    mem_op_i = MEM_SW; mem_addr_i = 32'h400; mem_sdata_i = 32'h1122_3344;
    wdata_i = 32'h0; wreg_i = 1'b0; wd_i = 5'd9;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_ram_wr", {31'd0, ram_wr_o}, 32'd0);
    check("midrst_stall", {31'd0, stallreq_o}, 32'd0);
    check("midrst_wd", {27'd0, wd_o}, 32'd0);
    check("midrst_ram_a", ram_a_o, 32'd0);
    mem_op_i = MEM_NOP;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_b0", {24'd0, mem[12'h400]}, 32'h44);
    check("midrst_b1", {24'd0, mem[12'h401]}, 32'h33);
    check("midrst_b2", {24'd0, mem[12'h402]}, 32'h00);
    check("midrst_b3", {24'd0, mem[12'h403]}, 32'h00);
    run_op(mk(MEM_LBU, 32'h401, 32'h0, 32'h0, 1'b1, 32'h33, 2, 0, 1'b1, 1'b0), 5'd10, "post_rst");
    go_nop();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
